// File: rtl/alu_arbiter_if.sv
// Requester-side bundle for alu_arbiter: two valid/ready request ports
// and their one-cycle response ports.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic [3:0]  req0_shift;
    logic [2:0]  req0_ctrl;
    logic        rsp0_valid;
    logic [15:0] rsp0_result;

    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic [3:0]  req1_shift;
    logic [2:0]  req1_ctrl;
    logic        rsp1_valid;
    logic [15:0] rsp1_result;
    logic [2:0]  rsp1_flags;

    modport master (
        output req0_valid, req0_a, req0_b, req0_shift, req0_ctrl,
        input  req0_ready, rsp0_valid, rsp0_result,
        output req1_valid, req1_a, req1_b, req1_shift, req1_ctrl,
        input  req1_ready, rsp1_valid, rsp1_result, rsp1_flags
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_shift, req0_ctrl,
        output req0_ready, rsp0_valid, rsp0_result,
        input  req1_valid, req1_a, req1_b, req1_shift, req1_ctrl,
        output req1_ready, rsp1_valid, rsp1_result, rsp1_flags
    );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the EX stage (port 0) and an auxiliary
// unit (port 1); owns the architectural [Z,V,N] flags.
module alu_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    alu_arbiter_if.slave bus,
    output logic [15:0]  alu_data_one,
    output logic [15:0]  alu_data_two,
    output logic [3:0]   alu_shift,
    output logic [2:0]   alu_control,
    input  logic [15:0]  alu_result,
    input  logic [2:0]   alu_flags,
    input  logic         alu_done,
    output logic [2:0]   flags_q
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic       grant0;
    logic       grant1;
    logic       can_grant;
    logic [3:0] starve_cnt;

    assign can_grant = !rst && !stall && alu_done;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (can_grant) begin
            grant1 = bus.req1_valid && (!bus.req0_valid || starve_cnt == LIMIT);
            grant0 = bus.req0_valid && !grant1;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    always_comb begin
        alu_data_one = '0;
        alu_data_two = '0;
        alu_shift    = '0;
        alu_control  = 3'b000;
        if (grant0) begin
            alu_data_one = bus.req0_a;
            alu_data_two = bus.req0_b;
            alu_shift    = bus.req0_shift;
            alu_control  = bus.req0_ctrl;
        end else if (grant1) begin
            alu_data_one = bus.req1_a;
            alu_data_two = bus.req1_b;
            alu_shift    = bus.req1_shift;
            alu_control  = bus.req1_ctrl;
        end
    end

    // Dropping req1_valid clears the count even during a stall; otherwise
    // stall / !alu_done freeze it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!bus.req1_valid || grant1) begin
            starve_cnt <= '0;
        end else if (!stall && alu_done && starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp0_valid  <= 1'b0;
            bus.rsp0_result <= '0;
            bus.rsp1_valid  <= 1'b0;
            bus.rsp1_result <= '0;
            bus.rsp1_flags  <= '0;
            flags_q         <= '0;
        end else begin
            bus.rsp0_valid <= grant0;
            bus.rsp1_valid <= grant1;
            if (grant0) begin
                bus.rsp0_result <= alu_result;
                // Shift opcodes (101..111) leave the architectural flags alone.
                if (bus.req0_ctrl <= 3'b100) begin
                    flags_q <= alu_flags;
                end
            end
            if (grant1) begin
                bus.rsp1_result <= alu_result;
                bus.rsp1_flags  <= alu_flags;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, directed vector table, hand-written
// starvation/stall/reset sequences and a randomized run against a reference model.
module tb_alu_arbiter;
    localparam int unsigned LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        alu_done = 1'b1;
    logic [15:0] alu_data_one, alu_data_two, alu_result;
    logic [3:0]  alu_shift;
    logic [2:0]  alu_control, alu_flags, flags_q;

    alu_arbiter_if bus();

    alu_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .stall(stall), .bus(bus),
        .alu_data_one(alu_data_one), .alu_data_two(alu_data_two),
        .alu_shift(alu_shift), .alu_control(alu_control),
        .alu_result(alu_result), .alu_flags(alu_flags), .alu_done(alu_done),
        .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    // Returns {Z,V,N, result}.
    function automatic logic [18:0] alu_fn(input logic [2:0] c, input logic [15:0] a,
                                           input logic [15:0] b, input logic [3:0] s);
        logic [15:0] r;
        logic        v;
        v = 1'b0;
        case (c)
            3'd0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
            3'd1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
            3'd2: r = ~(a & b);
            3'd3: r = a ^ b;
            3'd4: begin r = a + 16'd1; v = (a == 16'h7FFF); end
            3'd5: r = a << s;
            3'd6: r = a >> s;
            default: r = 16'($signed(a) >>> s);
        endcase
        return {(r == 16'd0), v, r[15], r};
    endfunction

    always_comb {alu_flags, alu_result} = alu_fn(alu_control, alu_data_one, alu_data_two, alu_shift);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: port 1 has waited m_wait cycles it could have been served.
    int          m_wait = 0;
    logic        m_g0, m_g1;
    logic        m_rsp0v = 0, m_rsp1v = 0;
    logic [15:0] m_rsp0r = 0, m_rsp1r = 0;
    logic [2:0]  m_rsp1f = 0, m_fq = 0;
    logic        obs_r0, obs_r1;

    task automatic model_grant();
        bit open;
        open = !rst && !stall && alu_done;
        m_g1 = open && bus.req1_valid && (!bus.req0_valid || m_wait == LIMIT);
        m_g0 = open && bus.req0_valid && !m_g1;
    endtask

    task automatic model_edge();
        logic [18:0] o0, o1;
        o0 = alu_fn(bus.req0_ctrl, bus.req0_a, bus.req0_b, bus.req0_shift);
        o1 = alu_fn(bus.req1_ctrl, bus.req1_a, bus.req1_b, bus.req1_shift);
        if (rst) begin
            m_rsp0v = 0; m_rsp1v = 0; m_rsp0r = 0; m_rsp1r = 0;
            m_rsp1f = 0; m_fq = 0; m_wait = 0;
        end else begin
            m_rsp0v = m_g0;
            m_rsp1v = m_g1;
            if (m_g0) begin
                m_rsp0r = o0[15:0];
                if (bus.req0_ctrl inside {[3'd0:3'd4]}) m_fq = o0[18:16];
            end
            if (m_g1) begin
                m_rsp1r = o1[15:0];
                m_rsp1f = o1[18:16];
            end
            if (!bus.req1_valid || m_g1) m_wait = 0;
            else if (!stall && alu_done && m_wait < LIMIT) m_wait = m_wait + 1;
        end
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic cycle();
        logic [15:0] ea, eb;
        logic [3:0]  es;
        logic [2:0]  ec;
        #1;
        model_grant();
        obs_r0 = bus.req0_ready;
        obs_r1 = bus.req1_ready;
        check("req0_ready", {15'd0, obs_r0}, {15'd0, m_g0});
        check("req1_ready", {15'd0, obs_r1}, {15'd0, m_g1});
        ea = '0; eb = '0; es = '0; ec = 3'b000;
        if (m_g0) begin
            ea = bus.req0_a; eb = bus.req0_b; es = bus.req0_shift; ec = bus.req0_ctrl;
        end else if (m_g1) begin
            ea = bus.req1_a; eb = bus.req1_b; es = bus.req1_shift; ec = bus.req1_ctrl;
        end
        check("alu_data_one", alu_data_one, ea);
        check("alu_data_two", alu_data_two, eb);
        check("alu_shift", {12'd0, alu_shift}, {12'd0, es});
        check("alu_control", {13'd0, alu_control}, {13'd0, ec});
        @(posedge clk);
        model_edge();
        #1;
        check("rsp0_valid", {15'd0, bus.rsp0_valid}, {15'd0, m_rsp0v});
        check("rsp0_result", bus.rsp0_result, m_rsp0r);
        check("rsp1_valid", {15'd0, bus.rsp1_valid}, {15'd0, m_rsp1v});
        check("rsp1_result", bus.rsp1_result, m_rsp1r);
        check("rsp1_flags", {13'd0, bus.rsp1_flags}, {13'd0, m_rsp1f});
        check("flags_q", {13'd0, flags_q}, {13'd0, m_fq});
        @(negedge clk);
    endtask

    task automatic set0(input logic v, input logic [2:0] c, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] s);
        bus.req0_valid = v; bus.req0_ctrl = c; bus.req0_a = a; bus.req0_b = b; bus.req0_shift = s;
    endtask

    task automatic set1(input logic v, input logic [2:0] c, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] s);
        bus.req1_valid = v; bus.req1_ctrl = c; bus.req1_a = a; bus.req1_b = b; bus.req1_shift = s;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; alu_done = 1'b1;
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        st, dn;
        logic        v0; logic [2:0] c0; logic [15:0] a0, b0; logic [3:0] s0;
        logic        v1; logic [2:0] c1; logic [15:0] a1, b1; logic [3:0] s1;
        logic        e_r0, e_r1, e_v0; logic [15:0] e_res0;
        logic        e_v1; logic [15:0] e_res1; logic [2:0] e_f1, e_fq;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{0,1, 1,0,16'h7FFF,16'h0001,0, 0,0,0,0,0, 1,0,1,16'h8000,0,16'h0000,3'b000,3'b011};
        vecs[1]  = '{0,1, 1,1,16'h0005,16'h0005,0, 0,0,0,0,0, 1,0,1,16'h0000,0,16'h0000,3'b000,3'b100};
        vecs[2]  = '{0,1, 1,5,16'h0001,16'h0000,4, 0,0,0,0,0, 1,0,1,16'h0010,0,16'h0000,3'b000,3'b100};
        vecs[3]  = '{0,1, 0,0,16'h0000,16'h0000,0, 0,0,0,0,0, 0,0,0,16'h0010,0,16'h0000,3'b000,3'b100};
        vecs[4]  = '{0,1, 0,0,16'h0000,16'h0000,0, 1,0,16'hFFFF,16'hFFFF,0, 0,1,0,16'h0010,1,16'hFFFE,3'b001,3'b100};
        vecs[5]  = '{0,1, 1,3,16'h00F0,16'h0F00,0, 0,0,0,0,0, 1,0,1,16'h0FF0,0,16'hFFFE,3'b001,3'b000};
        vecs[6]  = '{0,0, 0,0,16'h0000,16'h0000,0, 1,0,16'h1234,16'h0001,0, 0,0,0,16'h0FF0,0,16'hFFFE,3'b001,3'b000};
        vecs[7]  = '{1,1, 1,0,16'h0001,16'h0001,0, 0,0,0,0,0, 0,0,0,16'h0FF0,0,16'hFFFE,3'b001,3'b000};
        vecs[8]  = '{0,1, 1,0,16'h0001,16'h0002,0, 1,4,16'h0010,16'h0000,0, 1,0,1,16'h0003,0,16'hFFFE,3'b001,3'b000};
        vecs[9]  = '{0,1, 0,0,16'h0000,16'h0000,0, 1,4,16'h0010,16'h0000,0, 0,1,0,16'h0003,1,16'h0011,3'b000,3'b000};
        vecs[10] = '{0,1, 0,0,16'h0000,16'h0000,0, 1,7,16'h8000,16'h0000,3, 0,1,0,16'h0003,1,16'hF000,3'b001,3'b000};

        @(negedge clk);
        do_reset();
        check("reset rsp0_valid", {15'd0, bus.rsp0_valid}, 16'd0);
        check("reset rsp0_result", bus.rsp0_result, 16'd0);
        check("reset rsp1_valid", {15'd0, bus.rsp1_valid}, 16'd0);
        check("reset rsp1_result", bus.rsp1_result, 16'd0);
        check("reset rsp1_flags", {13'd0, bus.rsp1_flags}, 16'd0);
        check("reset flags_q", {13'd0, flags_q}, 16'd0);

        foreach (vecs[i]) begin
            stall = vecs[i].st; alu_done = vecs[i].dn;
            set0(vecs[i].v0, vecs[i].c0, vecs[i].a0, vecs[i].b0, vecs[i].s0);
            set1(vecs[i].v1, vecs[i].c1, vecs[i].a1, vecs[i].b1, vecs[i].s1);
            cycle();
            check($sformatf("vec%0d ready0", i), {15'd0, obs_r0}, {15'd0, vecs[i].e_r0});
            check($sformatf("vec%0d ready1", i), {15'd0, obs_r1}, {15'd0, vecs[i].e_r1});
            check($sformatf("vec%0d rsp0_valid", i), {15'd0, bus.rsp0_valid}, {15'd0, vecs[i].e_v0});
            check($sformatf("vec%0d rsp0_result", i), bus.rsp0_result, vecs[i].e_res0);
            check($sformatf("vec%0d rsp1_valid", i), {15'd0, bus.rsp1_valid}, {15'd0, vecs[i].e_v1});
            check($sformatf("vec%0d rsp1_result", i), bus.rsp1_result, vecs[i].e_res1);
            check($sformatf("vec%0d rsp1_flags", i), {13'd0, bus.rsp1_flags}, {13'd0, vecs[i].e_f1});
            check($sformatf("vec%0d flags_q", i), {13'd0, flags_q}, {13'd0, vecs[i].e_fq});
        end

        // Starvation: both valid from cycle 0 -> port 1 served in cycles 3 and 7.
        do_reset();
        set0(1, 0, 16'h0100, 16'h0001, 0);
        set1(1, 4, 16'h0200, 16'h0000, 0);
        for (int c = 0; c < 8; c++) begin
            cycle();
            check($sformatf("starve c%0d ready1", c), {15'd0, obs_r1}, {15'd0, (c == 3 || c == 7)});
            check($sformatf("starve c%0d ready0", c), {15'd0, obs_r0}, {15'd0, !(c == 3 || c == 7)});
        end

        // Stall freezes the wait count at 2.
        do_reset();
        set0(1, 0, 16'h0003, 16'h0004, 0);
        set1(1, 0, 16'h0005, 16'h0006, 0);
        cycle();
        cycle();
        stall = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            check("stall ready0", {15'd0, obs_r0}, 16'd0);
            check("stall ready1", {15'd0, obs_r1}, 16'd0);
            check("stall rsp0_valid", {15'd0, bus.rsp0_valid}, 16'd0);
            check("stall rsp1_valid", {15'd0, bus.rsp1_valid}, 16'd0);
        end
        stall = 1'b0;
        cycle();
        check("post-stall first ready0", {15'd0, obs_r0}, 16'd1);
        cycle();
        check("post-stall second ready1", {15'd0, obs_r1}, 16'd1);
        check("post-stall second ready0", {15'd0, obs_r0}, 16'd0);

        // Reset in the same cycle as a port-0 transfer, with stall also high.
        do_reset();
        set0(1, 0, 16'h7FFF, 16'h0001, 0);
        set1(1, 0, 16'h0001, 16'h0001, 0);
        cycle();
        check("pre-rst flags_q", {13'd0, flags_q}, 16'h0003);
        rst = 1'b1; stall = 1'b1;
        cycle();
        check("rst ready0", {15'd0, obs_r0}, 16'd0);
        check("rst rsp0_valid", {15'd0, bus.rsp0_valid}, 16'd0);
        check("rst flags_q", {13'd0, flags_q}, 16'd0);
        check("rst rsp0_result", bus.rsp0_result, 16'd0);
        rst = 1'b0; stall = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cycle();
            check($sformatf("post-rst c%0d ready1", c), {15'd0, obs_r1}, {15'd0, (c == 3)});
        end

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(63) == 0);
            stall    = ($urandom_range(7) == 0);
            alu_done = ($urandom_range(7) != 0);
            set0($urandom_range(3) != 0, 3'($urandom), 16'($urandom), 16'($urandom), 4'($urandom));
            set1($urandom_range(1) != 0, 3'($urandom), 16'($urandom), 16'($urandom), 4'($urandom));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational 16-bit ALU between two requesters: port 0 (pipeline EX stage) and port 1 (auxiliary unit, e.g. address/increment generation).
- Owns the architectural [Z,V,N] flag register, updated only by port-0 arithmetic/logic ops.
- Drives the ALU operand/control inputs and registers the ALU outputs, giving each port a valid/ready request and a 1-cycle response.

Parameters:
- STARVE_LIMIT, 3, max consecutive cycles port 1 may wait while valid before it is force-granted (legal range 1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stall  in  1  blocks all grants while high.
- req0_valid  in  1  port-0 request.
- req0_ready  out  1  port-0 grant.
- req0_a, req0_b  in  16 each  port-0 operands.
- req0_shift  in  4  port-0 shift amount.
- req0_ctrl  in  3  port-0 opcode.
- rsp0_valid  out  1  port-0 response strobe.
- rsp0_result  out  16  port-0 result.
- req1_valid, req1_ready, req1_a, req1_b, req1_shift, req1_ctrl  same as port 0, for port 1.
- rsp1_valid  out  1  port-1 response strobe.
- rsp1_result  out  16  port-1 result.
- rsp1_flags  out  3  ALU flags for the port-1 op.
- alu_data_one, alu_data_two  out  16 each  to ALU.
- alu_shift  out  4  to ALU.
- alu_control  out  3  to ALU.
- alu_result  in  16  from ALU.
- alu_flags  in  3  from ALU, [Z,V,N].
- alu_done  in  1  from ALU.
- flags_q  out  3  architectural flags [Z,V,N].

Behaviour:
- Clock, reset: one clock; reset is synchronous and active-high.
- Reset values: rsp0_valid=0, rsp1_valid=0, rsp0_result=0, rsp1_result=0, rsp1_flags=000, flags_q=000, starve_cnt=0.
- Grants are combinational from the current inputs and starve_cnt. At most one grant per cycle.
- No grant when stall=1, alu_done=0 or rst=1.
- Otherwise:
  - grant1 = req1_valid && (!req0_valid || starve_cnt==STARVE_LIMIT).
  - grant0 = req0_valid && !grant1.
- req0_ready = grant0; req1_ready = grant1. A transfer occurs when valid && ready.
- ALU drive:
  - Granted port's a/b/shift/ctrl are muxed onto alu_data_one, alu_data_two, alu_shift, alu_control.
  - No grant: drive 0, 0, 0, 3'b000 (ADD).
- Response, latency 1:
  - At the edge ending a port-N transfer: rspN_valid<=1 and rspN_result<=alu_result; for port 1 also rsp1_flags<=alu_flags.
  - rspN_valid is a single-cycle pulse. It deasserts at the next edge unless a new port-N transfer occurs; back-to-back transfers give continuous valid.
  - Responses have no backpressure.
  - rspN_result and rsp1_flags hold their last value when valid is low.
- Flag register:
  - At the edge ending a port-0 transfer with req0_ctrl in {000..100} (ADD, SUB, NAND, XOR, INC): flags_q<=alu_flags.
  - Shift opcodes (101, 110, 111) leave flags_q unchanged.
  - Port-1 ops never modify flags_q.
- Starvation counter, 4 bits, saturating at STARVE_LIMIT:
  - Increments at an edge where req1_valid && !grant1 && !stall && alu_done.
  - Clears on a port-1 transfer or when req1_valid=0.
  - Holds while stall=1 or alu_done=0.
- Boundaries:
  - Both valid, starve_cnt<STARVE_LIMIT: port 0 wins.
  - starve_cnt==STARVE_LIMIT: port 1 wins even if port 0 is valid.
  - Requester dropping valid without a grant: legal, no transfer.
  - Operand changes while ungranted are ignored.
- Reset mid-operation:
  - A transfer presented in the reset cycle is discarded: no response and no flag update.
  - All registers take their reset values.
  - Reset dominates stall.

Test Plan:
- Reset, then port 0 ADD a=0x7FFF, b=0x0001 -> req0_ready=1 same cycle; next cycle rsp0_valid=1, rsp0_result=0x8000, flags_q=3'b011.
- Port 0 SUB a=0x0005, b=0x0005, then SLL a=0x0001, shift=4 on consecutive cycles -> rsp0_valid high 2 cycles; results 0x0000 then 0x0010; flags_q=3'b100 after SUB and still 3'b100 after SLL.
- STARVE_LIMIT=3; req0_valid and req1_valid held high from cycle 0 -> grants port 0 in cycles 0-2, port 1 in cycle 3, port 0 in cycles 4-6, port 1 in cycle 7.
- Port 1 alone, ADD a=0xFFFF, b=0xFFFF -> rsp1_result=0xFFFE, rsp1_flags=3'b001, flags_q unchanged from its prior value.
- stall=1 for 5 cycles with both ports valid and starve_cnt=2 -> no ready, no rsp, starve_cnt stays 2; after stall drops, port 0 is granted once and then port 1 is granted.
- rst asserted in the same cycle as a port-0 ADD transfer -> no rsp0_valid next cycle, flags_q=000, starve_cnt=0.
